// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed, XOR-checksummed byte image into
// instruction memory as 16-bit words and keeps the core in reset until the
// whole image has been written and verified.
module imem_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_wr_en,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wr_data,
    output logic        cpu_rst,
    output logic        done,
    output logic        err,
    output logic [15:0] words_loaded
);

    localparam int unsigned BW = 8;
    localparam int unsigned WW = 16;
    localparam int unsigned AW = 16;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN_HI  = 3'd1,
        S_LEN_LO  = 3'd2,
        S_DATA_HI = 3'd3,
        S_DATA_LO = 3'd4,
        S_CHK     = 3'd5,
        S_DONE    = 3'd6,
        S_ERR     = 3'd7
    } state_t;

    state_t          r_state;
    state_t          w_next;

    // Registered outputs
    logic            r_in_ready;
    logic            r_mem_wr_en;
    logic            r_cpu_rst;
    logic            r_done;
    logic            r_err;
    logic [AW-1:0]   r_mem_addr;
    logic [WW-1:0]   r_mem_wr_data;
    logic [WW-1:0]   r_words_loaded;

    // Datapath state
    logic [BW-1:0]   r_len_hi;
    logic [WW-1:0]   r_len;
    logic [BW-1:0]   r_hi;
    logic [BW-1:0]   r_chk;

    // Next values of the registered control outputs
    logic            w_in_ready_nxt;
    logic            w_mem_wr_en_nxt;
    logic            w_cpu_rst_nxt;
    logic            w_done_nxt;
    logic            w_err_nxt;

    logic            w_xfer;
    logic            w_start_go;
    logic [WW-1:0]   w_len_full;
    logic            w_oversize;
    logic            w_last_word;

    // A byte moves only when the loader advertised ready for this cycle.
    assign w_xfer      = in_valid & r_in_ready;
    assign w_start_go  = start & ((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERR));
    assign w_len_full  = {r_len_hi, in_data};
    assign w_oversize  = w_len_full > WW'(MAX_WORDS);
    // words_loaded has already caught up with every earlier word by the time
    // the next low byte can arrive, so it is the index of the current word.
    assign w_last_word = (r_words_loaded + WW'(1)) == r_len;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (w_xfer) w_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (w_xfer) begin
                    if (w_oversize)             w_next = S_ERR;
                    else if (w_len_full == '0)  w_next = S_CHK;
                    else                        w_next = S_DATA_HI;
                end
            end
            S_DATA_HI: begin
                if (w_xfer) w_next = S_DATA_LO;
            end
            S_DATA_LO: begin
                if (w_xfer) w_next = w_last_word ? S_CHK : S_DATA_HI;
            end
            S_CHK: begin
                if (w_xfer) w_next = (in_data == r_chk) ? S_DONE : S_ERR;
            end
            S_DONE: begin
                if (start) w_next = S_LEN_HI;
            end
            S_ERR: begin
                if (start) w_next = S_LEN_HI;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line up with it
    always_comb begin
        w_in_ready_nxt  = 1'b0;
        w_cpu_rst_nxt   = 1'b1;
        w_done_nxt      = 1'b0;
        w_err_nxt       = 1'b0;
        w_mem_wr_en_nxt = 1'b0;
        case (w_next)
            S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHK: begin
                w_in_ready_nxt = 1'b1;
            end
            S_DONE: begin
                w_done_nxt    = 1'b1;
                w_cpu_rst_nxt = 1'b0;
            end
            S_ERR: begin
                w_err_nxt = 1'b1;
            end
            default: begin
                w_in_ready_nxt = 1'b0;
            end
        endcase
        w_mem_wr_en_nxt = (r_state == S_DATA_LO) & w_xfer;
    end

    // Control output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_ready  <= 1'b0;
            r_mem_wr_en <= 1'b0;
            r_cpu_rst   <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_in_ready  <= w_in_ready_nxt;
            r_mem_wr_en <= w_mem_wr_en_nxt;
            r_cpu_rst   <= w_cpu_rst_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
        end
    end

    // Length capture and word assembly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len_hi      <= '0;
            r_len         <= '0;
            r_hi          <= '0;
            r_mem_wr_data <= '0;
        end else if (w_xfer) begin
            case (r_state)
                S_LEN_HI:  r_len_hi      <= in_data;
                S_LEN_LO:  r_len         <= w_len_full;
                S_DATA_HI: r_hi          <= in_data;
                S_DATA_LO: r_mem_wr_data <= {r_hi, in_data};
                default:   r_hi          <= r_hi;
            endcase
        end
    end

    // Running XOR over every accepted byte except the checksum byte itself
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chk <= '0;
        end else if (w_start_go) begin
            r_chk <= '0;
        end else if (w_xfer && (r_state != S_CHK)) begin
            r_chk <= r_chk ^ in_data;
        end
    end

    // Write address and word counter advance once the strobe has been presented
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_addr     <= BASE_ADDR;
            r_words_loaded <= '0;
        end else if (w_start_go) begin
            r_mem_addr     <= BASE_ADDR;
            r_words_loaded <= '0;
        end else if (r_mem_wr_en) begin
            r_mem_addr     <= r_mem_addr + AW'(2);
            r_words_loaded <= r_words_loaded + WW'(1);
        end
    end

    assign in_ready     = r_in_ready;
    assign mem_wr_en    = r_mem_wr_en;
    assign mem_addr     = r_mem_addr;
    assign mem_wr_data  = r_mem_wr_data;
    assign cpu_rst      = r_cpu_rst;
    assign done         = r_done;
    assign err          = r_err;
    assign words_loaded = r_words_loaded;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and random images parsed by a stream-level
// reference model; a second instance based near the top of the address space
// exercises 16-bit address wrap with identical stimulus.
module tb_imem_loader;

    localparam logic [15:0] BASE   = 16'h0000;
    localparam logic [15:0] BASE_W = 16'hFFFC;
    localparam int          MAXW   = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;

    logic        in_ready,   in_ready_w;
    logic        mem_wr_en,  mem_wr_en_w;
    logic [15:0] mem_addr,   mem_addr_w;
    logic [15:0] mem_wr_data, mem_wr_data_w;
    logic        cpu_rst,    cpu_rst_w;
    logic        done,       done_w;
    logic        err,        err_w;
    logic [15:0] words_loaded, words_loaded_w;

    imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) u_dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .cpu_rst(cpu_rst), .done(done), .err(err),
        .words_loaded(words_loaded)
    );

    imem_loader #(.BASE_ADDR(BASE_W), .MAX_WORDS(MAXW)) u_dut_w (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_w), .mem_wr_en(mem_wr_en_w), .mem_addr(mem_addr_w),
        .mem_wr_data(mem_wr_data_w), .cpu_rst(cpu_rst_w), .done(done_w), .err(err_w),
        .words_loaded(words_loaded_w)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stimulus image and the model's expectations for it
    logic [7:0]  stim[$];
    int          exp_idx[$];
    logic [15:0] exp_dat[$];
    bit          exp_done;
    bit          exp_err;
    int          exp_words;
    int          exp_nbytes;

    // Reference model: parse the image by its format rules
    task automatic model();
        int n;
        logic [7:0] x;
        exp_idx.delete();
        exp_dat.delete();
        n = int'({stim[0], stim[1]});
        if (n > MAXW) begin
            exp_err    = 1'b1;
            exp_done   = 1'b0;
            exp_words  = 0;
            exp_nbytes = 2;
        end else begin
            x = 8'h00;
            for (int i = 0; i < 2 + 2 * n; i++) x = x ^ stim[i];
            for (int i = 0; i < n; i++) begin
                exp_idx.push_back(i);
                exp_dat.push_back({stim[2 + 2 * i], stim[3 + 2 * i]});
            end
            exp_words  = n;
            exp_done   = (stim[2 + 2 * n] == x);
            exp_err    = !exp_done;
            exp_nbytes = 3 + 2 * n;
        end
    endtask

    task automatic gen(input int n, input bit corrupt);
        logic [7:0] x;
        stim.delete();
        stim.push_back(8'(n >> 8));
        stim.push_back(8'(n));
        if (n <= MAXW) begin
            for (int i = 0; i < 2 * n; i++) stim.push_back(8'($urandom));
            x = 8'h00;
            foreach (stim[i]) x = x ^ stim[i];
            stim.push_back(corrupt ? (x ^ 8'($urandom_range(255, 1))) : x);
        end
    endtask

    // Write monitor: every strobe must match the next expected word
    always @(negedge clk) begin
        if (mem_wr_en) begin
            if (exp_dat.size() == 0) begin
                check("unexpected_wr", 32'd1, 32'd0);
            end else begin
                check("wr_addr",      32'(mem_addr),      32'(16'(BASE + 16'(2 * exp_idx[0]))));
                check("wr_data",      32'(mem_wr_data),   32'(exp_dat[0]));
                check("wr_en_wrap",   32'(mem_wr_en_w),   32'd1);
                check("wr_addr_wrap", 32'(mem_addr_w),    32'(16'(BASE_W + 16'(2 * exp_idx[0]))));
                check("wr_data_wrap", 32'(mem_wr_data_w), 32'(exp_dat[0]));
                void'(exp_idx.pop_front());
                void'(exp_dat.pop_front());
            end
        end
    end

    task automatic check_reset();
        check("rst_in_ready",  32'(in_ready),     32'd0);
        check("rst_wr_en",     32'(mem_wr_en),    32'd0);
        check("rst_addr",      32'(mem_addr),     32'(BASE));
        check("rst_wr_data",   32'(mem_wr_data),  32'd0);
        check("rst_cpu_rst",   32'(cpu_rst),      32'd1);
        check("rst_done",      32'(done),         32'd0);
        check("rst_err",       32'(err),          32'd0);
        check("rst_words",     32'(words_loaded), 32'd0);
        check("rst_addr_wrap", 32'(mem_addr_w),   32'(BASE_W));
    endtask

    // Start pulse, optionally with a byte offered that must not be taken
    task automatic do_start();
        start    = 1'b1;
        in_valid = 1'($urandom);
        in_data  = 8'($urandom);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        check("st_in_ready", 32'(in_ready),     32'd1);
        check("st_cpu_rst",  32'(cpu_rst),      32'd1);
        check("st_done",     32'(done),         32'd0);
        check("st_err",      32'(err),          32'd0);
        check("st_words",    32'(words_loaded), 32'd0);
        check("st_addr",     32'(mem_addr),     32'(BASE));
    endtask

    // Offer one byte after an idle gap; stray start pulses must be ignored
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            start    = ($urandom_range(7, 0) == 0);
            @(negedge clk);
            check("ready_wait", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b1;
        in_data  = b;
        start    = ($urandom_range(7, 0) == 0);
        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) check("byte_timeout", 32'd0, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic run_load(input int gap_lo, input int gap_hi);
        model();
        do_start();
        for (int i = 0; i < exp_nbytes; i++)
            send_byte(stim[i], $urandom_range(gap_hi, gap_lo));
        repeat (2) @(negedge clk);
        check("fin_done",     32'(done),           32'(exp_done));
        check("fin_err",      32'(err),            32'(exp_err));
        check("fin_cpu_rst",  32'(cpu_rst),        32'(!exp_done));
        check("fin_words",    32'(words_loaded),   32'(exp_words));
        check("fin_in_ready", 32'(in_ready),       32'd0);
        check("fin_wr_left",  32'(exp_dat.size()), 32'd0);
        check("fin_done_w",   32'(done_w),         32'(exp_done));
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_reset();
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd0);
        check("idle_cpu_rst",  32'(cpu_rst),  32'd1);

        // Nominal image
        stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        run_load(0, 0);

        // Bad checksum
        stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
        run_load(0, 0);

        // Oversize count
        stim = '{8'h01, 8'h01};
        run_load(0, 0);

        // Empty image
        stim = '{8'h00, 8'h00, 8'h00};
        run_load(0, 0);

        // Three idle cycles before every byte
        stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        run_load(3, 3);

        // Asynchronous reset partway through a load
        exp_idx.delete();
        exp_dat.delete();
        do_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        run_load(0, 0);

        // Largest accepted count, then one beyond it
        gen(MAXW, 1'b0);
        run_load(0, 0);
        gen(MAXW + 1, 1'b0);
        run_load(0, 0);

        // Random images
        for (int k = 0; k < 30; k++) begin
            case ($urandom_range(7, 0))
                0:       gen($urandom_range(65535, MAXW + 1), 1'b0);
                1, 2:    gen($urandom_range(12, 0), 1'b1);
                default: gen($urandom_range(12, 0), 1'b0);
            endcase
            run_load(0, $urandom_range(2, 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program loader that fills instruction memory before the single-cycle core runs; it is the writer paired with the core's fetch-side reader.
- Accepts a byte stream over a valid/ready handshake and assembles 16-bit instruction words.
- Writes each word to consecutive even byte addresses, matching the core's PC+2 stride.
- Holds the core in reset until a complete, checksum-verified image is in memory.

Parameters:
- BASE_ADDR, 16'h0000, byte address written by the first word.
- MAX_WORDS, 256, largest accepted word count.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; sampled only in IDLE, DONE or ERR.
- in_valid  input  1  in_data holds a valid byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle; transfer occurs when in_valid & in_ready.
- mem_wr_en  output  1  one-cycle instruction-memory write strobe.
- mem_addr  output  16  byte address for the write.
- mem_wr_data  output  16  instruction word to write.
- cpu_rst  output  1  reset to the core; high until a load completes.
- done  output  1  load completed successfully (level).
- err  output  1  load failed (level).
- words_loaded  output  16  number of words written in the current load.

Behaviour:
Reset (async, rst=1):
- State=IDLE.
- in_ready=0, mem_wr_en=0, mem_addr=BASE_ADDR, mem_wr_data=0.
- cpu_rst=1, done=0, err=0, words_loaded=0.
- Checksum register=0, word count register=0.
- Reset mid-load abandons the load; memory writes already issued are not undone.

Stream format:
- LEN_HI, LEN_LO: word count N, big-endian.
- N words, each sent as high byte then low byte.
- CHK: a single checksum byte, equal to the XOR of every preceding byte including both length bytes.

States:
- IDLE: in_ready=0. On start -> LEN_HI; clear checksum and words_loaded; mem_addr=BASE_ADDR.
- LEN_HI: in_ready=1. On transfer, latch N[15:8] -> LEN_LO.
- LEN_LO: in_ready=1. On transfer, latch N[7:0], then:
  - full N > MAX_WORDS -> ERR;
  - N == 0 -> CHK;
  - otherwise -> DATA_HI.
- DATA_HI: in_ready=1. On transfer, latch the high byte -> DATA_LO.
- DATA_LO: in_ready=1. On transfer:
  - next cycle mem_wr_en=1 for exactly one cycle, with mem_wr_data={hi,lo} and mem_addr at the current address;
  - the cycle after the strobe, mem_addr advances by 2 and words_loaded increments;
  - if words_loaded+1 == N -> CHK, else -> DATA_HI.
- CHK: in_ready=1. On transfer, compare the byte with the running XOR: equal -> DONE, mismatch -> ERR.
- DONE: in_ready=0, done=1, cpu_rst=0. On start -> LEN_HI; cpu_rst=1 and done=0 from the next cycle.
- ERR: in_ready=0, err=1, cpu_rst=1. On start -> LEN_HI; err=0.

Checksum and handshake rules:
- The running XOR updates on every accepted byte except the CHK byte itself.
- Back-to-back bytes are accepted every cycle. The write is registered, so no stall cycle is inserted.
- in_valid=0 holds the current state indefinitely. in_data is ignored when no transfer occurs.

Address arithmetic:
- 16-bit and wrapping; 16'hFFFE + 2 = 16'h0000.
- There is no bounds check beyond MAX_WORDS.

Simultaneous and out-of-turn events:
- start asserted in LEN_HI through CHK is ignored.
- start together with in_valid in IDLE: only the state change happens; the byte is not accepted because in_ready=0 in IDLE.

Test Plan:
- Nominal load: start, then bytes 00 02 12 34 AB CD 42 -> writes (0000,1234) then (0002,ABCD); done=1, cpu_rst=0, words_loaded=2, err=0.
- Bad checksum: same stream with last byte 43 -> both writes occur; ERR with err=1, cpu_rst=1, done=0.
- Oversize count: 01 01 (N=257, MAX_WORDS=256) -> ERR right after the second byte; no mem_wr_en pulses; in_ready=0.
- Empty image: 00 00 00 -> DONE with zero writes; words_loaded=0.
- Handshake gaps: nominal stream with in_valid low for 3 cycles between every byte -> identical writes and final state; in_ready stays high while waiting.
- Async reset mid-load: rst asserted after byte 12 -> all outputs take their reset values immediately; start then the nominal stream -> writes begin again at BASE_ADDR.
